// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like bus bundle shared by the two cache masters and the memory port.
//
// Handshake: a master raises req and holds wr/size/addr/wdata stable while req
// is high; the address phase completes in the cycle where req and addr_ok are
// both 1. data_ok pulses for one cycle when the data phase completes, and
// rdata is valid only in that cycle. Only one transaction is outstanding at a
// time.
//
// Modports:
//   master - drives req/wr/size/addr/wdata, receives rdata/addr_ok/data_ok
//   slave  - receives req/wr/size/addr/wdata, drives rdata/addr_ok/data_ok
interface mem_bus_arbiter_if #(
  parameter int A_WIDTH = 32
);
  logic               req;
  logic               wr;
  logic [1:0]         size;
  logic [A_WIDTH-1:0] addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               addr_ok;
  logic               data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like memory port between the I-cache miss
// path (inst) and the D-side (data). One transaction in flight at a time: the
// address phase is granted to one master and stays locked to it until that
// master's data phase completes (or it withdraws its request before the
// address is accepted).
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   inst       I-master bus (slave modport)
//   data       D-master bus (slave modport)
//   mem        memory-side bus (master modport)
//   state_dbg  current FSM state encoding
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - when both masters request in IDLE, the one not granted last wins
//               (last_grant resets to I and updates on each address handshake)
//   undefined - fixed priority, D over I
//
// Address and data paths are purely combinational; only the FSM (and
// last_grant when enabled) is registered.
module mem_bus_arbiter #(
  parameter int A_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_arbiter_if.slave        inst,
  mem_bus_arbiter_if.slave        data,
  mem_bus_arbiter_if.master       mem,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_t;

  state_t             state;
  logic               grant_d;   // 1: the D-master owns the memory-side mux
  logic               idle_pick_d;
  logic               m_req_c;
  logic               handshake;
  logic [A_WIDTH-1:0] addr_mux;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;                  // 1: last address handshake belonged to D
  // Under contention the master that was not served last wins.
  assign idle_pick_d = data.req & (~inst.req | ~last_d);
`else
  assign idle_pick_d = data.req;
`endif

  always_comb begin
    grant_d = 1'b0;
    m_req_c = 1'b0;
    case (state)
      IDLE: begin
        grant_d = idle_pick_d;
        m_req_c = inst.req | data.req;
      end
      REQ_I: begin
        grant_d = 1'b0;
        m_req_c = inst.req;
      end
      REQ_D: begin
        grant_d = 1'b1;
        m_req_c = data.req;
      end
      WAIT_I: grant_d = 1'b0;
      WAIT_D: grant_d = 1'b1;
      default: begin
        grant_d = 1'b0;
        m_req_c = 1'b0;
      end
    endcase
  end

  assign addr_mux  = grant_d ? data.addr : inst.addr;
  assign mem.req   = m_req_c;
  assign mem.wr    = grant_d ? data.wr    : inst.wr;
  assign mem.size  = grant_d ? data.size  : inst.size;
  assign mem.addr  = addr_mux;
  assign mem.wdata = grant_d ? data.wdata : inst.wdata;

  // m_req_c is 0 in WAIT, so addr_ok can never leak out during a data phase.
  assign handshake    = m_req_c & mem.addr_ok;
  assign inst.addr_ok = handshake & ~grant_d;
  assign data.addr_ok = handshake &  grant_d;

  // data_ok outside WAIT is not ours to forward.
  assign inst.data_ok = mem.data_ok & (state == WAIT_I);
  assign data.data_ok = mem.data_ok & (state == WAIT_D);

  assign inst.rdata = mem.rdata;
  assign data.rdata = mem.rdata;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_d <= 1'b0;
`endif
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (handshake) last_d <= grant_d;
`endif
      case (state)
        IDLE: begin
          if (inst.req | data.req) begin
            if (grant_d) state <= mem.addr_ok ? WAIT_D : REQ_D;
            else         state <= mem.addr_ok ? WAIT_I : REQ_I;
          end
        end
        // A withdrawn request means nothing was issued: back to IDLE silently.
        REQ_I: begin
          if (!inst.req)        state <= IDLE;
          else if (mem.addr_ok) state <= WAIT_I;
        end
        REQ_D: begin
          if (!data.req)        state <= IDLE;
          else if (mem.addr_ok) state <= WAIT_D;
        end
        WAIT_I: if (mem.data_ok) state <= IDLE;
        WAIT_D: if (mem.data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
